adma_as_atx_gen: RTL and testbench
==================================

Name: adma_as_atx_gen

Overview:
- Per-channel AXI transaction generator in the DMA address-sequencing path.
- Accepts one descriptor (source address, destination address, length in beats) and splits it into a sequence of paired AR/AW transactions.
- Each transaction is capped at the maximum burst length and never crosses a 4 KB boundary on either side.
- One instance per DMA channel; its transaction output feeds one requester slot of the channel transaction arbiter.

Parameters:
CHN_ID, 0, channel index; value driven on atx_arid/atx_awid
SRC_ADDR_W, 32, source address width
DST_ADDR_W, 32, destination address width
DMA_LENGTH_W, 16, descriptor length width (beats)
MST_ID_W, 5, AXI ID width
ATX_LEN_W, 8, AXI AxLEN width; max burst = 2^ATX_LEN_W beats
DATA_W, 32, data bus width in bits; BYTES = DATA_W/8 (power of two)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
desc_src_addr  in  SRC_ADDR_W  descriptor source address, BYTES-aligned
desc_dst_addr  in  DST_ADDR_W  descriptor destination address, BYTES-aligned
desc_len  in  DMA_LENGTH_W  total beats
desc_vld  in  1  descriptor valid
desc_rdy  out  1  descriptor ready
atx_arid  out  MST_ID_W  AR ID
atx_araddr  out  SRC_ADDR_W  AR address
atx_arlen  out  ATX_LEN_W  AR length (beats-1)
atx_arburst  out  2  AR burst type
atx_awid  out  MST_ID_W  AW ID
atx_awaddr  out  DST_ADDR_W  AW address
atx_awlen  out  ATX_LEN_W  AW length (beats-1)
atx_awburst  out  2  AW burst type
atx_vld  out  1  transaction valid (to arbiter)
atx_rdy  in  1  transaction ready (from arbiter)
atx_done  out  1  one-cycle pulse: descriptor fully issued
busy  out  1  high when the state is not IDLE

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous, active-low.
- Reset values: state IDLE, atx_vld=0, atx_done=0, busy=0, desc_rdy=1, all address/length outputs 0, bursts 2'b01.
- FSM states: IDLE, CALC, ISSUE.
- IDLE:
  - desc_rdy=1.
  - On desc_vld&desc_rdy: latch src, dst, remaining=desc_len.
  - If desc_len==0: stay IDLE and pulse atx_done on the next cycle; no atx_vld.
  - Otherwise go to CALC.
- CALC (one cycle), desc_rdy=0:
  - Compute beats = min(remaining, 2^ATX_LEN_W, s4k, d4k).
  - s4k = (4096 - src[11:0]) >> log2(BYTES); d4k is the same using dst.
  - Register outputs: araddr=src, awaddr=dst, arlen=awlen=beats-1, ids=CHN_ID, bursts=INCR (2'b01).
  - Go to ISSUE.
- ISSUE:
  - atx_vld=1; all atx_* outputs held stable until atx_vld&atx_rdy.
  - On handshake: src+=beats*BYTES, dst+=beats*BYTES, remaining-=beats.
  - If the new remaining==0: pulse atx_done in the following cycle and go to IDLE. Otherwise go to CALC.
- Latency:
  - Descriptor handshake at cycle T → atx_vld at T+2.
  - Transaction handshake at T → next atx_vld at T+2.
  - Final handshake at T → atx_done at T+1 and desc_rdy at T+1.
- Widths and arithmetic:
  - beats is ATX_LEN_W+1 bits wide.
  - Address low log2(BYTES) bits are treated as zero.
  - Address increment wraps modulo 2^ADDR_W, with no error.
- atx_vld never drops without a handshake. atx_rdy is ignored outside ISSUE.
- A new descriptor is accepted in the same cycle atx_done is high.
- Reset asserted mid-operation: immediate return to reset values; the partially issued descriptor is discarded.

Optional Feature:
- Macro ADMA_ATX_GEN_STAT_EN.
- Defined: adds output atx_cnt (DMA_LENGTH_W bits).
  - Cleared on descriptor accept.
  - Incremented on each atx handshake.
  - Holds its value after atx_done until the next accept.
  - Reset value 0.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package adma_pkg:
  - AXI burst encodings (FIXED/INCR/WRAP).
  - 4 KB boundary constant (4096).
  - FSM state enum for this block.
- One sub-module, adma_as_atx_len_calc: combinational min of remaining, max burst, s4k, d4k; outputs beats.

Test Plan (DATA_W=32, ATX_LEN_W=8, CHN_ID=2):
1. src=0x1000, dst=0x2000, len=16 → one ATX: araddr 0x1000, awaddr 0x2000, arlen=awlen=15, ids 2, bursts 2'b01; atx_done 1 cycle after the handshake.
2. src=0x0, dst=0x10000, len=600, atx_rdy=1 → three ATX with arlen 255, 255, 87; araddr 0x0, 0x400, 0x800; awaddr 0x10000, 0x10400, 0x10800; atx_done once.
3. src=0xFF0, dst=0x3000, len=8 → ATX1: araddr 0xFF0, awaddr 0x3000, len 3; ATX2: araddr 0x1000, awaddr 0x3010, len 3.
4. Case 1 with atx_rdy low for 5 cycles in ISSUE → atx_vld stays 1 and all atx_* stable for 5 cycles; single handshake when atx_rdy rises.
5. len=0 accepted → atx_done pulses next cycle, atx_vld never asserts, desc_rdy stays 1.
6. rst_n low while atx_vld=1 mid-descriptor → atx_vld=0 and busy=0 asynchronously; after release, desc_rdy=1 and a new descriptor per case 1 completes normally.

Source files
------------

// File: rtl/adma_pkg.sv
// Shared definitions for the DMA address-sequencing path.
//   - AXI burst type encodings
//   - 4 KB AXI boundary size
//   - state encoding of the per-channel transaction generator
package adma_pkg;

   localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
   localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
   localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

   localparam int unsigned ADMA_4K_BYTES = 4096;

   typedef enum logic [1:0] {
      ATX_IDLE  = 2'd0,
      ATX_CALC  = 2'd1,
      ATX_ISSUE = 2'd2
   } atx_state_e;

endpackage

// File: rtl/adma_as_atx_len_calc.sv
// Combinational beat-count calculator for one AXI transaction.
// beats = min(remaining, 2^ATX_LEN_W, beats left in source 4 KB page,
//             beats left in destination 4 KB page)
// Ports:
//   rem_i      remaining beats of the descriptor (non-zero when used)
//   src_off_i  source address bits [11:0]
//   dst_off_i  destination address bits [11:0]
//   beats_o    beats for this transaction, ATX_LEN_W+1 bits
module adma_as_atx_len_calc
   import adma_pkg::*;
#(
   parameter int unsigned DMA_LENGTH_W = 16,
   parameter int unsigned ATX_LEN_W    = 8,
   parameter int unsigned DATA_W       = 32
) (
   input  logic [DMA_LENGTH_W-1:0] rem_i,
   input  logic [11:0]             src_off_i,
   input  logic [11:0]             dst_off_i,
   output logic [ATX_LEN_W:0]      beats_o
);

   localparam int unsigned BYTE_SH = $clog2(DATA_W / 8);
   localparam int unsigned BEATS_W = ATX_LEN_W + 1;
   localparam int unsigned W0      = (DMA_LENGTH_W > BEATS_W) ? DMA_LENGTH_W : BEATS_W;
   localparam int unsigned CMP_W   = (W0 > 13) ? W0 : 13;
   // sub-beat offset bits are ignored
   localparam logic [11:0] OFF_MASK = ~12'(DATA_W / 8 - 1);

   logic [12:0]      s4k_bytes, d4k_bytes;
   logic [CMP_W-1:0] rem_w, max_w, s4k_w, d4k_w, min_a, min_b, min_c;

   always_comb begin
      s4k_bytes = 13'(ADMA_4K_BYTES) - {1'b0, src_off_i & OFF_MASK};
      d4k_bytes = 13'(ADMA_4K_BYTES) - {1'b0, dst_off_i & OFF_MASK};
      rem_w     = CMP_W'(rem_i);
      max_w     = CMP_W'(1) << ATX_LEN_W;
      s4k_w     = CMP_W'(s4k_bytes >> BYTE_SH);
      d4k_w     = CMP_W'(d4k_bytes >> BYTE_SH);
      min_a     = (rem_w < max_w) ? rem_w : max_w;
      min_b     = (s4k_w < d4k_w) ? s4k_w : d4k_w;
      min_c     = (min_a < min_b) ? min_a : min_b;
      beats_o   = BEATS_W'(min_c);
   end

endmodule

// File: rtl/adma_as_atx_gen.sv
// Per-channel AXI transaction generator. Takes one descriptor
// (src, dst, beats) and issues paired AR/AW transactions, each capped at
// the max burst length and never crossing a 4 KB page on either side.
// Ports:
//   clk, rst_n                clock, async active-low reset
//   desc_* / desc_vld/rdy     descriptor input handshake
//   atx_ar* / atx_aw*         registered transaction payload
//   atx_vld / atx_rdy         transaction handshake to the arbiter
//   atx_done                  one-cycle pulse once a descriptor is fully issued
//   busy                      state is not IDLE
//   atx_cnt                   handshakes issued for the current descriptor
//                             (only with ADMA_ATX_GEN_STAT_EN defined)
module adma_as_atx_gen
   import adma_pkg::*;
#(
   parameter int unsigned CHN_ID       = 0,
   parameter int unsigned SRC_ADDR_W   = 32,
   parameter int unsigned DST_ADDR_W   = 32,
   parameter int unsigned DMA_LENGTH_W = 16,
   parameter int unsigned MST_ID_W     = 5,
   parameter int unsigned ATX_LEN_W    = 8,
   parameter int unsigned DATA_W       = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [SRC_ADDR_W-1:0]   desc_src_addr,
   input  logic [DST_ADDR_W-1:0]   desc_dst_addr,
   input  logic [DMA_LENGTH_W-1:0] desc_len,
   input  logic                    desc_vld,
   output logic                    desc_rdy,
   output logic [MST_ID_W-1:0]     atx_arid,
   output logic [SRC_ADDR_W-1:0]   atx_araddr,
   output logic [ATX_LEN_W-1:0]    atx_arlen,
   output logic [1:0]              atx_arburst,
   output logic [MST_ID_W-1:0]     atx_awid,
   output logic [DST_ADDR_W-1:0]   atx_awaddr,
   output logic [ATX_LEN_W-1:0]    atx_awlen,
   output logic [1:0]              atx_awburst,
   output logic                    atx_vld,
   input  logic                    atx_rdy,
   output logic                    atx_done,
   output logic                    busy
`ifdef ADMA_ATX_GEN_STAT_EN
   ,
   output logic [DMA_LENGTH_W-1:0] atx_cnt
`endif
);

   localparam int unsigned BYTES   = DATA_W / 8;
   localparam int unsigned BYTE_SH = $clog2(BYTES);
   localparam int unsigned BEATS_W = ATX_LEN_W + 1;
   localparam logic [SRC_ADDR_W-1:0] SRC_MASK = ~SRC_ADDR_W'(BYTES - 1);
   localparam logic [DST_ADDR_W-1:0] DST_MASK = ~DST_ADDR_W'(BYTES - 1);

   atx_state_e state_q, state_d;

   logic [SRC_ADDR_W-1:0]   src_q, src_d;
   logic [DST_ADDR_W-1:0]   dst_q, dst_d;
   logic [DMA_LENGTH_W-1:0] rem_q, rem_d;
   logic [BEATS_W-1:0]      beats_q, beats_d;
   logic [BEATS_W-1:0]      beats_c;
   logic [DMA_LENGTH_W-1:0] cnt_q, cnt_d;

   logic                    desc_rdy_q, desc_rdy_d;
   logic                    vld_q, vld_d;
   logic                    done_q, done_d;
   logic                    busy_q, busy_d;
   logic [MST_ID_W-1:0]     id_q, id_d;
   logic [1:0]              burst_q, burst_d;
   logic [SRC_ADDR_W-1:0]   araddr_q, araddr_d;
   logic [DST_ADDR_W-1:0]   awaddr_q, awaddr_d;
   logic [ATX_LEN_W-1:0]    len_q, len_d;

   adma_as_atx_len_calc #(
      .DMA_LENGTH_W (DMA_LENGTH_W),
      .ATX_LEN_W    (ATX_LEN_W),
      .DATA_W       (DATA_W)
   ) u_len_calc (
      .rem_i     (rem_q),
      .src_off_i (src_q[11:0]),
      .dst_off_i (dst_q[11:0]),
      .beats_o   (beats_c)
   );

   // Next-state and registered-output logic
   always_comb begin
      state_d  = state_q;
      src_d    = src_q;
      dst_d    = dst_q;
      rem_d    = rem_q;
      beats_d  = beats_q;
      cnt_d    = cnt_q;
      vld_d    = vld_q;
      done_d   = 1'b0;
      id_d     = id_q;
      burst_d  = burst_q;
      araddr_d = araddr_q;
      awaddr_d = awaddr_q;
      len_d    = len_q;

      unique case (state_q)
         ATX_IDLE: begin
            if (desc_vld && desc_rdy_q) begin
               src_d = desc_src_addr & SRC_MASK;
               dst_d = desc_dst_addr & DST_MASK;
               rem_d = desc_len;
               cnt_d = '0;
               // zero-length descriptor completes without any transaction
               if (desc_len == '0) done_d  = 1'b1;
               else                state_d = ATX_CALC;
            end
         end
         ATX_CALC: begin
            araddr_d = src_q;
            awaddr_d = dst_q;
            len_d    = ATX_LEN_W'(beats_c - BEATS_W'(1));
            beats_d  = beats_c;
            id_d     = MST_ID_W'(CHN_ID);
            burst_d  = AXI_BURST_INCR;
            vld_d    = 1'b1;
            state_d  = ATX_ISSUE;
         end
         ATX_ISSUE: begin
            if (atx_rdy) begin
               vld_d = 1'b0;
               src_d = src_q + (SRC_ADDR_W'(beats_q) << BYTE_SH);
               dst_d = dst_q + (DST_ADDR_W'(beats_q) << BYTE_SH);
               rem_d = rem_q - DMA_LENGTH_W'(beats_q);
               cnt_d = cnt_q + DMA_LENGTH_W'(1);
               if (rem_d == '0) begin
                  done_d  = 1'b1;
                  state_d = ATX_IDLE;
               end else begin
                  state_d = ATX_CALC;
               end
            end
         end
         default: begin
            vld_d   = 1'b0;
            state_d = ATX_IDLE;
         end
      endcase

      desc_rdy_d = (state_d == ATX_IDLE);
      busy_d     = (state_d != ATX_IDLE);
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ATX_IDLE;
         src_q      <= '0;
         dst_q      <= '0;
         rem_q      <= '0;
         beats_q    <= '0;
         cnt_q      <= '0;
         desc_rdy_q <= 1'b1;
         vld_q      <= 1'b0;
         done_q     <= 1'b0;
         busy_q     <= 1'b0;
         id_q       <= '0;
         burst_q    <= AXI_BURST_INCR;
         araddr_q   <= '0;
         awaddr_q   <= '0;
         len_q      <= '0;
      end else begin
         state_q    <= state_d;
         src_q      <= src_d;
         dst_q      <= dst_d;
         rem_q      <= rem_d;
         beats_q    <= beats_d;
         cnt_q      <= cnt_d;
         desc_rdy_q <= desc_rdy_d;
         vld_q      <= vld_d;
         done_q     <= done_d;
         busy_q     <= busy_d;
         id_q       <= id_d;
         burst_q    <= burst_d;
         araddr_q   <= araddr_d;
         awaddr_q   <= awaddr_d;
         len_q      <= len_d;
      end
   end

   assign desc_rdy    = desc_rdy_q;
   assign atx_arid    = id_q;
   assign atx_awid    = id_q;
   assign atx_araddr  = araddr_q;
   assign atx_awaddr  = awaddr_q;
   assign atx_arlen   = len_q;
   assign atx_awlen   = len_q;
   assign atx_arburst = burst_q;
   assign atx_awburst = burst_q;
   assign atx_vld     = vld_q;
   assign atx_done    = done_q;
   assign busy        = busy_q;

`ifdef ADMA_ATX_GEN_STAT_EN
   assign atx_cnt = cnt_q;
`else
   logic unused_cnt;
   assign unused_cnt = ^cnt_q;
`endif

endmodule

// File: tb/tb_adma_as_atx_gen.sv
// Bench for adma_as_atx_gen (DATA_W=32, ATX_LEN_W=8, CHN_ID=2).
// A transaction-list model predicts every AR/AW pair of a descriptor;
// a negedge monitor compares the DUT against it every cycle.
module tb_adma_as_atx_gen;

   localparam int unsigned CHN = 2;

   typedef struct packed {
      logic [31:0] ar;
      logic [31:0] aw;
      logic [7:0]  len;
   } atx_t;

   logic        clk, rst_n;
   logic [31:0] desc_src_addr, desc_dst_addr;
   logic [15:0] desc_len;
   logic        desc_vld, desc_rdy;
   logic [4:0]  atx_arid, atx_awid;
   logic [31:0] atx_araddr, atx_awaddr;
   logic [7:0]  atx_arlen, atx_awlen;
   logic [1:0]  atx_arburst, atx_awburst;
   logic        atx_vld, atx_rdy, atx_done, busy;
`ifdef ADMA_ATX_GEN_STAT_EN
   logic [15:0] atx_cnt;
`endif

   adma_as_atx_gen #(
      .CHN_ID       (CHN),
      .SRC_ADDR_W   (32),
      .DST_ADDR_W   (32),
      .DMA_LENGTH_W (16),
      .MST_ID_W     (5),
      .ATX_LEN_W    (8),
      .DATA_W       (32)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .desc_src_addr (desc_src_addr),
      .desc_dst_addr (desc_dst_addr),
      .desc_len      (desc_len),
      .desc_vld      (desc_vld),
      .desc_rdy      (desc_rdy),
      .atx_arid      (atx_arid),
      .atx_araddr    (atx_araddr),
      .atx_arlen     (atx_arlen),
      .atx_arburst   (atx_arburst),
      .atx_awid      (atx_awid),
      .atx_awaddr    (atx_awaddr),
      .atx_awlen     (atx_awlen),
      .atx_awburst   (atx_awburst),
      .atx_vld       (atx_vld),
      .atx_rdy       (atx_rdy),
      .atx_done      (atx_done),
      .busy          (busy)
`ifdef ADMA_ATX_GEN_STAT_EN
      ,
      .atx_cnt       (atx_cnt)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int   n_vec = 0;
   int   n_err = 0;
   int   cyc = 0;
   int   rdy_mode = 0;   // 0: always ready, 1: random, 2: stalled

   atx_t exp_q[$];
   atx_t hs_log[$];
   bit   m_busy = 0;
   bit   m_vld = 0;
   int   vld_due = -1;
   int   done_due = -1;
   int   done_cnt = 0;
   int   last_hs_cyc = 0;
   int   last_done_cyc = 0;
   int   m_cnt = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Split a descriptor into transactions from the burst/4 KB rules
   task automatic model_gen(input logic [31:0] s_in, input logic [31:0] d_in, input int len);
      logic [31:0] s, d;
      int rem, b, sb, db;
      atx_t t;
      s = s_in & 32'hFFFF_FFFC;
      d = d_in & 32'hFFFF_FFFC;
      rem = len;
      while (rem > 0) begin
         b  = (rem > 256) ? 256 : rem;
         sb = (4096 - int'(s & 32'hFFF)) / 4;
         db = (4096 - int'(d & 32'hFFF)) / 4;
         if (b > sb) b = sb;
         if (b > db) b = db;
         t.ar = s;
         t.aw = d;
         t.len = 8'(b - 1);
         exp_q.push_back(t);
         s = s + 32'(b * 4);
         d = d + 32'(b * 4);
         rem = rem - b;
      end
   endtask

   // Per-cycle compare against the model
   initial begin
      atx_t h;
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst_n) begin
            exp_q.delete();
            m_busy = 0; m_vld = 0; vld_due = -1; done_due = -1; m_cnt = 0;
            chk("rst_desc_rdy", desc_rdy, 1);
            chk("rst_vld", atx_vld, 0);
            chk("rst_done", atx_done, 0);
            chk("rst_busy", busy, 0);
            chk("rst_araddr", atx_araddr, 0);
            chk("rst_awaddr", atx_awaddr, 0);
            chk("rst_len", {atx_arlen, atx_awlen}, 0);
            chk("rst_bursts", {atx_arburst, atx_awburst}, 4'b0101);
         end else begin
            if (cyc == vld_due) m_vld = 1;
            chk("desc_rdy", desc_rdy, !m_busy);
            chk("busy", busy, m_busy);
            chk("atx_vld", atx_vld, m_vld);
            chk("atx_done", atx_done, cyc == done_due);
            if (atx_done) begin done_cnt++; last_done_cyc = cyc; end
`ifdef ADMA_ATX_GEN_STAT_EN
            chk("atx_cnt", atx_cnt, 16'(m_cnt));
`endif
            if (m_vld && exp_q.size() > 0) begin
               h = exp_q[0];
               chk("araddr", atx_araddr, h.ar);
               chk("awaddr", atx_awaddr, h.aw);
               chk("arlen", atx_arlen, h.len);
               chk("awlen", atx_awlen, h.len);
               chk("ids", {atx_arid, atx_awid}, {5'(CHN), 5'(CHN)});
               chk("bursts", {atx_arburst, atx_awburst}, 4'b0101);
            end
            // events taking effect at the coming edge
            if (m_vld && atx_rdy) begin
               h = exp_q.pop_front();
               hs_log.push_back(h);
               last_hs_cyc = cyc;
               m_vld = 0;
               m_cnt++;
               if (exp_q.size() == 0) begin
                  m_busy = 0;
                  done_due = cyc + 1;
               end else begin
                  vld_due = cyc + 2;
               end
            end else if (!m_busy && desc_vld) begin
               m_cnt = 0;
               model_gen(desc_src_addr, desc_dst_addr, int'(desc_len));
               if (exp_q.size() == 0) begin
                  done_due = cyc + 1;
               end else begin
                  m_busy = 1;
                  vld_due = cyc + 2;
               end
            end
         end
      end
   end

   // Arbiter-side ready
   initial begin
      atx_rdy = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         atx_rdy = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 2) ? 1'b0 : ($urandom_range(0, 3) != 0);
      end
   end

   task automatic send_desc(input logic [31:0] s, input logic [31:0] d, input logic [15:0] len);
      bit ok;
      ok = 0;
      @(posedge clk);
      #1;
      desc_src_addr = s; desc_dst_addr = d; desc_len = len; desc_vld = 1'b1;
      for (int i = 0; i < 5000; i++) begin
         @(negedge clk);
         if (desc_rdy) begin ok = 1; break; end
      end
      if (!ok) chk("desc_accept_timeout", 0, 1);
      @(posedge clk);
      #1;
      desc_vld = 1'b0;
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 0;
      for (int i = 0; i < 8000; i++) begin
         @(negedge clk);
         #2;
         if (!m_busy && cyc >= done_due) begin ok = 1; break; end
      end
      if (!ok) chk("idle_timeout", 0, 1);
   endtask

   task automatic wait_vld();
      bit ok;
      ok = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         #2;
         if (atx_vld) begin ok = 1; break; end
      end
      if (!ok) chk("vld_timeout", 0, 1);
   endtask

   task automatic case1_check(input string tag);
      int d0;
      hs_log.delete();
      d0 = done_cnt;
      send_desc(32'h1000, 32'h2000, 16);
      wait_idle();
      chk({tag, "_n"}, hs_log.size(), 1);
      chk({tag, "_ar"}, hs_log[0].ar, 32'h1000);
      chk({tag, "_aw"}, hs_log[0].aw, 32'h2000);
      chk({tag, "_len"}, hs_log[0].len, 15);
      chk({tag, "_done_n"}, done_cnt - d0, 1);
      chk({tag, "_done_lat"}, last_done_cyc - last_hs_cyc, 1);
   endtask

   initial begin
      int d0, n0;
      logic [31:0] s, d;
      rst_n = 1'b0;
      desc_vld = 1'b0;
      desc_src_addr = '0; desc_dst_addr = '0; desc_len = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // 1: single transaction
      rdy_mode = 0;
      case1_check("t1");

      // 2: burst-length split
      hs_log.delete();
      d0 = done_cnt;
      send_desc(32'h0, 32'h10000, 600);
      wait_idle();
      chk("t2_n", hs_log.size(), 3);
      chk("t2_len0", hs_log[0].len, 255);
      chk("t2_len1", hs_log[1].len, 255);
      chk("t2_len2", hs_log[2].len, 87);
      chk("t2_ar1", hs_log[1].ar, 32'h400);
      chk("t2_ar2", hs_log[2].ar, 32'h800);
      chk("t2_aw0", hs_log[0].aw, 32'h10000);
      chk("t2_aw2", hs_log[2].aw, 32'h10800);
      chk("t2_done_n", done_cnt - d0, 1);

      // 3: source 4 KB crossing
      hs_log.delete();
      send_desc(32'hFF0, 32'h3000, 8);
      wait_idle();
      chk("t3_n", hs_log.size(), 2);
      chk("t3_ar0", hs_log[0].ar, 32'hFF0);
      chk("t3_len0", hs_log[0].len, 3);
      chk("t3_ar1", hs_log[1].ar, 32'h1000);
      chk("t3_aw1", hs_log[1].aw, 32'h3010);
      chk("t3_len1", hs_log[1].len, 3);

      // 4: stalled arbiter keeps payload stable
      hs_log.delete();
      rdy_mode = 2;
      send_desc(32'h1000, 32'h2000, 16);
      wait_vld();
      for (int i = 0; i < 5; i++) begin
         if (i > 0) begin @(negedge clk); #2; end
         chk("t4_vld", atx_vld, 1);
         chk("t4_ar", atx_araddr, 32'h1000);
         chk("t4_aw", atx_awaddr, 32'h2000);
         chk("t4_len", atx_arlen, 15);
      end
      rdy_mode = 0;
      wait_idle();
      chk("t4_n", hs_log.size(), 1);

      // 5: zero length
      hs_log.delete();
      d0 = done_cnt;
      send_desc(32'h5000, 32'h6000, 0);
      wait_idle();
      repeat (3) @(negedge clk);
      chk("t5_n", hs_log.size(), 0);
      chk("t5_done_n", done_cnt - d0, 1);

      // 6: reset in the middle of a descriptor
      rdy_mode = 2;
      send_desc(32'h0, 32'h10000, 600);
      wait_vld();
      @(negedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("t6_vld_async", atx_vld, 0);
      chk("t6_busy_async", busy, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      rdy_mode = 0;
      @(negedge clk);
      #2;
      chk("t6_desc_rdy", desc_rdy, 1);
      case1_check("t6");

      // random descriptors, random arbiter ready, back-to-back issue
      rdy_mode = 1;
      n0 = done_cnt;
      send_desc(32'hFFFF_FFC0, 32'h0000_0F00, 40);  // address wrap
      for (int k = 0; k < 40; k++) begin
         s = $urandom & 32'hFFFF_FFFC;
         d = $urandom & 32'hFFFF_FFFC;
         if ($urandom_range(0, 1) == 1) s = (s & 32'hFFFF_F000) | (32'hF00 + 32'($urandom_range(0, 63) * 4));
         if ($urandom_range(0, 1) == 1) d = (d & 32'hFFFF_F000) | (32'hE00 + 32'($urandom_range(0, 127) * 4));
         send_desc(s, d, 16'($urandom_range(0, 700)));
      end
      wait_idle();
      chk("rand_done_n", done_cnt - n0, 41);
      chk("rand_q_empty", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
